// File: rtl/jericalla_secuenciador.sv
// Instruction sequencer for the jericalla datapath: holds a small program and
// issues one word every two cycles, halting on a zero word, on Zflag or at the end.
module jericalla_secuenciador #(
  parameter int ANCHO_INSTR = 17,
  parameter int ANCHO_PC    = 4,
  parameter int PROF        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   carga_en,
  input  logic [ANCHO_PC-1:0]    carga_dir,
  input  logic [ANCHO_INSTR-1:0] carga_dato,
  input  logic                   inicio,
  input  logic                   alto_en_cero,
  input  logic                   zflag,
  output logic [ANCHO_INSTR-1:0] instruccion,
  output logic                   instr_valida,
  output logic [ANCHO_PC-1:0]    pc,
  output logic                   ocupado,
  output logic                   fin,
  output logic [ANCHO_PC:0]      cuenta
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} estado_t;

  localparam logic [ANCHO_PC-1:0] PC_MAX     = ANCHO_PC'(PROF - 1);
  localparam logic [ANCHO_PC:0]   CUENTA_MAX = (ANCHO_PC + 1)'(PROF);

  estado_t                estado_reg;
  logic [ANCHO_INSTR-1:0] prog_mem [PROF];
  logic                   carga_ok;
  logic                   parar;

  // Loading is only allowed while stopped, so a running program never changes under itself.
  assign carga_ok = carga_en && (estado_reg == IDLE || estado_reg == HALT);

  // Memory has no reset on purpose: the program survives rst.
  always_ff @(posedge clk) begin
    if (carga_ok) begin
      prog_mem[carga_dir] <= carga_dato;
    end
  end

  // During EXEC, instruccion is the held word, so the halt decision reads it directly.
  assign parar = (instruccion == '0) || (alto_en_cero && zflag) || (pc == PC_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_reg   <= IDLE;
      instruccion  <= '0;
      instr_valida <= 1'b0;
      pc           <= '0;
      ocupado      <= 1'b0;
      fin          <= 1'b0;
      cuenta       <= '0;
    end else begin
      case (estado_reg)
        IDLE, HALT: begin
          if (inicio) begin
            estado_reg <= FETCH;
            pc         <= '0;
            cuenta     <= '0;
            ocupado    <= 1'b1;
            fin        <= 1'b0;
          end
        end
        FETCH: begin
          instruccion  <= prog_mem[pc];
          instr_valida <= 1'b1;
          estado_reg   <= EXEC;
        end
        EXEC: begin
          instruccion  <= '0;
          instr_valida <= 1'b0;
          if (cuenta != CUENTA_MAX) begin
            cuenta <= cuenta + 1'b1;
          end
          if (parar) begin
            estado_reg <= HALT;
            ocupado    <= 1'b0;
            fin        <= 1'b1;
          end else begin
            pc         <= pc + 1'b1;
            estado_reg <= FETCH;
          end
        end
        default: estado_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jericalla_secuenciador.sv
// Directed self-checking bench for jericalla_secuenciador: load, run, halt
// conditions, load gating, asynchronous reset and restart with a same-edge load.
module tb_jericalla_secuenciador;

  localparam int AI = 17;
  localparam int AP = 4;
  localparam int PR = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          carga_en;
  logic [AP-1:0] carga_dir;
  logic [AI-1:0] carga_dato;
  logic          inicio;
  logic          alto_en_cero;
  logic          zflag;
  logic [AI-1:0] instruccion;
  logic          instr_valida;
  logic [AP-1:0] pc;
  logic          ocupado;
  logic          fin;
  logic [AP:0]   cuenta;

  logic [AI-1:0] zword = 17'd9;
  int            checks = 0;
  int            errors = 0;

  logic [AI-1:0] issued_q[$];
  logic [AP-1:0] pc_q[$];
  int            cyc_q[$];
  bit            timed_out;

  jericalla_secuenciador #(.ANCHO_INSTR(AI), .ANCHO_PC(AP), .PROF(PR)) dut (
    .clk(clk), .rst(rst), .carga_en(carga_en), .carga_dir(carga_dir),
    .carga_dato(carga_dato), .inicio(inicio), .alto_en_cero(alto_en_cero),
    .zflag(zflag), .instruccion(instruccion), .instr_valida(instr_valida),
    .pc(pc), .ocupado(ocupado), .fin(fin), .cuenta(cuenta)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: Zflag is raised only while the word at address 3 is on the bus.
  assign zflag = instr_valida && (instruccion == zword);

  function automatic logic [AI-1:0] patron(input int a);
    return AI'(17'h00001 + ((a + 1) << 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [AI-1:0] d);
    carga_en   = 1'b1;
    carga_dir  = AP'(a);
    carga_dato = d;
    tick();
    carga_en   = 1'b0;
  endtask

  task automatic load_pattern();
    for (int a = 0; a < PR; a++) load(a, patron(a));
  endtask

  // Pulses inicio (optionally with a same-edge load) and records every issue until fin.
  task automatic run_collect(input bit ld, input int ld_dir, input logic [AI-1:0] ld_dato);
    issued_q.delete();
    pc_q.delete();
    cyc_q.delete();
    timed_out  = 1'b0;
    inicio     = 1'b1;
    carga_en   = ld;
    carga_dir  = AP'(ld_dir);
    carga_dato = ld_dato;
    tick();
    inicio   = 1'b0;
    carga_en = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (instr_valida) begin
        issued_q.push_back(instruccion);
        pc_q.push_back(pc);
        cyc_q.push_back(c);
        $display("issue %0d: pc=%0d instruccion=%05h cuenta=%0d", issued_q.size(), pc, instruccion, cuenta);
      end
      if (fin) return;
    end
    timed_out = 1'b1;
  endtask

  task automatic wait_fin(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (fin) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; carga_en = 1'b0; carga_dir = '0; carga_dato = '0;
    inicio = 1'b0; alto_en_cero = 1'b0;
    tick(); tick();
    checks++;
    if ({instruccion, instr_valida, pc, ocupado, fin, cuenta} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got instr=%05h v=%b pc=%0d oc=%b fin=%b cuenta=%0d, need all 0",
               instruccion, instr_valida, pc, ocupado, fin, cuenta);
    end
    rst = 1'b0;
    tick();
    $display("reset released");
  endtask

  task automatic test_run_to_end();
    int bad;
    load_pattern();
    run_collect(1'b0, 0, '0);
    checks++;
    if (timed_out || issued_q.size() != 16) begin
      errors++;
      $display("FAIL end_issue_count: got %0d (timeout=%b), need 16", issued_q.size(), timed_out);
    end
    bad = 0;
    foreach (issued_q[k]) begin
      if (issued_q[k] !== patron(k) || pc_q[k] !== AP'(k) || cyc_q[k] != 1 + 2 * k) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL end_issue_seq: %0d issues wrong (value, pc or cycle), need 0", bad);
    end
    checks++;
    if (fin !== 1'b1 || ocupado !== 1'b0 || cuenta !== 5'd16 || instruccion !== '0 || pc !== 4'd15) begin
      errors++;
      $display("FAIL end_halt_state: got fin=%b oc=%b cuenta=%0d instr=%05h pc=%0d, need 1 0 16 0 15",
               fin, ocupado, cuenta, instruccion, pc);
    end
  endtask

  task automatic test_halt_word();
    logic [AI-1:0] exp [3];
    exp[0] = 17'b00100010010001101;
    exp[1] = 17'h1ABCD;
    exp[2] = 17'h00000;
    for (int a = 0; a < 3; a++) load(a, exp[a]);
    run_collect(1'b0, 0, '0);
    checks++;
    if (timed_out || issued_q.size() != 3) begin
      errors++;
      $display("FAIL halt_word_count: got %0d (timeout=%b), need 3", issued_q.size(), timed_out);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (issued_q[k] !== exp[k]) begin
          errors++;
          $display("FAIL halt_word_issue%0d: got %05h, need %05h", k, issued_q[k], exp[k]);
        end
      end
    end
    checks++;
    if (fin !== 1'b1 || pc !== 4'd2 || cuenta !== 5'd3) begin
      errors++;
      $display("FAIL halt_word_state: got fin=%b pc=%0d cuenta=%0d, need 1 2 3", fin, pc, cuenta);
    end
  endtask

  task automatic test_stop_on_zero();
    load_pattern();
    alto_en_cero = 1'b1;
    run_collect(1'b0, 0, '0);
    checks++;
    if (timed_out || issued_q.size() != 4 || issued_q[issued_q.size()-1] !== zword) begin
      errors++;
      $display("FAIL zstop_issues: got %0d issues (timeout=%b), need 4 ending in %05h",
               issued_q.size(), timed_out, zword);
    end
    checks++;
    if (fin !== 1'b1 || pc !== 4'd3 || cuenta !== 5'd4) begin
      errors++;
      $display("FAIL zstop_state: got fin=%b pc=%0d cuenta=%0d, need 1 3 4", fin, pc, cuenta);
    end
    alto_en_cero = 1'b0;
    run_collect(1'b0, 0, '0);
    checks++;
    if (timed_out || issued_q.size() != 16 || pc !== 4'd15) begin
      errors++;
      $display("FAIL zignore_run: got %0d issues pc=%0d (timeout=%b), need 16 pc=15",
               issued_q.size(), pc, timed_out);
    end
  endtask

  task automatic test_load_gating();
    bit ok;
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    tick(); tick();
    checks++;
    if (ocupado !== 1'b1) begin
      errors++;
      $display("FAIL gate_busy: got ocupado=%b, need 1", ocupado);
    end
    load(5, 17'h1FFFF);
    wait_fin(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL gate_fin_timeout: got fin=%b, need 1", fin);
    end
    run_collect(1'b0, 0, '0);
    checks++;
    if (issued_q.size() < 6 || issued_q[5] !== patron(5)) begin
      errors++;
      $display("FAIL gate_addr5: got %0d issues, addr5=%05h, need %05h",
               issued_q.size(), (issued_q.size() >= 6) ? issued_q[5] : 17'h0, patron(5));
    end
  endtask

  task automatic test_async_reset();
    int bad;
    bit seen;
    seen   = 1'b0;
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (instr_valida && pc == 4'd2) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL areset_reach_exec: got no issue at pc=2, need one");
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (instruccion !== '0 || instr_valida !== 1'b0 || pc !== '0 || cuenta !== '0) begin
      errors++;
      $display("FAIL areset_immediate: got instr=%05h v=%b pc=%0d cuenta=%0d, need all 0",
               instruccion, instr_valida, pc, cuenta);
    end
    #1 rst = 1'b0;
    tick(); tick();
    checks++;
    if (ocupado !== 1'b0 || fin !== 1'b0 || instr_valida !== 1'b0) begin
      errors++;
      $display("FAIL areset_idle: got oc=%b fin=%b v=%b, need 0 0 0", ocupado, fin, instr_valida);
    end
    run_collect(1'b0, 0, '0);
    bad = 0;
    foreach (issued_q[k]) if (issued_q[k] !== patron(k)) bad++;
    checks++;
    if (timed_out || issued_q.size() != 16 || bad != 0) begin
      errors++;
      $display("FAIL areset_replay: got %0d issues, %0d wrong, need 16 and 0", issued_q.size(), bad);
    end
  endtask

  task automatic test_restart_load();
    bit ok;
    inicio     = 1'b1;
    carga_en   = 1'b1;
    carga_dir  = '0;
    carga_dato = 17'h00003;
    tick();
    inicio   = 1'b0;
    carga_en = 1'b0;
    checks++;
    if (cuenta !== 5'd0 || fin !== 1'b0) begin
      errors++;
      $display("FAIL restart_clear: got cuenta=%0d fin=%b, need 0 0", cuenta, fin);
    end
    tick();
    checks++;
    if (instr_valida !== 1'b1 || instruccion !== 17'h00003) begin
      errors++;
      $display("FAIL restart_first_issue: got v=%b instr=%05h, need 1 00003", instr_valida, instruccion);
    end
    $display("issue 1: pc=%0d instruccion=%05h cuenta=%0d", pc, instruccion, cuenta);
    tick();
    checks++;
    if (cuenta !== 5'd1) begin
      errors++;
      $display("FAIL restart_cuenta: got %0d, need 1", cuenta);
    end
    wait_fin(ok);
    checks++;
    if (!ok || cuenta !== 5'd16) begin
      errors++;
      $display("FAIL restart_end: got fin=%b cuenta=%0d, need 1 16", fin, cuenta);
    end
  endtask

  initial begin
    test_reset();
    test_run_to_end();
    test_halt_word();
    test_stop_on_zero();
    test_load_gating();
    test_async_reset();
    test_restart_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
